// File: rtl/factorial_pkg.sv
// Shared constants, error codes and FSM encoding for the factorial scheduler.
package factorial_pkg;

    localparam int MAX_N_32 = 12;   // 12! is the largest factorial that fits 32 bits
    localparam int FACT_TMO = 20;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/factorial_sched_if.sv
// Client-side request/response bus of the factorial scheduler.
interface factorial_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 8,
    parameter int RES_W   = 32
);
    // Requests: a requester holds req_valid/req_in until it sees its one-hot req_ready
    // strobe. Responses: rsp_* is stable while rsp_valid=1 and retires on rsp_valid & rsp_ready.
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_in;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [2:0]              rsp_id;
    logic [RES_W-1:0]        rsp_result;
    logic [1:0]              rsp_err;

    modport master (
        output req_valid, req_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_in, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/factorial_sched_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, take lowest set bit, rotate back.
module factorial_sched_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         idx,
    output logic               any
);
    localparam logic [3:0] N4 = 4'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [2:0]         k;
    logic [3:0]         sum;

    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        k   = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) k = 3'(i);
        end
        sum = {1'b0, k} + {1'b0, ptr};
        if (sum >= N4) sum = sum - N4;
        idx = sum[2:0];
        any = |req;
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = any && (idx == 3'(i));
        end
    end
endmodule

// File: rtl/factorial_sched.sv
// Round-robin scheduler sharing one multi-cycle factorial engine among NUM_REQ clients.
module factorial_sched
    import factorial_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 8,
    parameter int RES_W   = 32,
    parameter int MAX_N   = MAX_N_32,
    parameter int TMO     = FACT_TMO
) (
    input  logic             clk,
    input  logic             rst,
    factorial_sched_if.slave bus,
    output logic             eng_start,
    output logic [IN_W-1:0]  eng_in,
    input  logic             eng_done,
    input  logic [RES_W-1:0] eng_result,
    output logic             busy,
    output state_t           dbg_state
);
    localparam int              CW       = $clog2(TMO + 1);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TMO - 1);
    localparam logic [IN_W-1:0] MAX_OP   = IN_W'(MAX_N);
    localparam logic [3:0]      N4       = 4'(NUM_REQ);

    state_t             state, state_n;
    logic [2:0]         rr_ptr, ptr_nxt, gidx, id_q;
    logic [NUM_REQ-1:0] gnt;
    logic               any_req, grant, op_bad;
    logic [IN_W-1:0]    op_sel, op_q;
    logic [RES_W-1:0]   res_q;
    logic [1:0]         err_q;
    logic [CW-1:0]      cnt;
    logic [3:0]         ptr_sum;

    factorial_sched_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any_req)
    );

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) op_sel = bus.req_in[i*IN_W +: IN_W];
        end
        op_bad  = op_sel > MAX_OP;
        ptr_sum = {1'b0, gidx} + 4'd1;
        ptr_nxt = (ptr_sum >= N4) ? 3'd0 : ptr_sum[2:0];
    end

    // Grants are suppressed while reset is held so req_ready reads 0 during reset.
    assign grant = rst && (state == IDLE) && any_req;

    always_comb begin
        state_n       = state;
        bus.req_ready = '0;
        eng_start     = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant) begin
                    bus.req_ready = gnt;
                    state_n       = op_bad ? RESP : LAUNCH;
                end
            end
            LAUNCH: begin
                eng_start = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (eng_done || cnt == TMO_LAST) state_n = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= 3'd0;
            op_q   <= '0;
            id_q   <= 3'd0;
            res_q  <= '0;
            err_q  <= ERR_OK;
            cnt    <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (grant) begin
                        rr_ptr <= ptr_nxt;
                        id_q   <= gidx;
                        res_q  <= '0;
                        err_q  <= op_bad ? ERR_RANGE : ERR_OK;
                        // Out-of-range operands never reach the engine's input.
                        if (!op_bad) op_q <= op_sel;
                    end
                end
                LAUNCH: cnt <= '0;
                WAIT: begin
                    if (eng_done) begin
                        res_q <= eng_result;
                        err_q <= ERR_OK;
                    end else if (cnt == TMO_LAST) begin
                        res_q <= '0;
                        err_q <= ERR_TMO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_in         = op_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;
    assign dbg_state      = state;
endmodule
